// File: rtl/mag_sched.sv
// mag_sched: round-robin time-sharing of one mag12 estimator across NCH I/Q channels, with in-order tag return.
// Optional per-channel peak hold enabled by defining MAG_SCHED_PEAK_EN.
module mag_sched #(
   parameter int NCH   = 4,
   parameter int CW    = 2,
   parameter int TAGD  = 8,
   parameter int FLUSH = 8
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [12*NCH-1:0] in_x,
   input  logic [12*NCH-1:0] in_y,
   input  logic [NCH-1:0]    in_v,
   output logic [NCH-1:0]    in_rdy,
   output logic [11:0]       mag_x,
   output logic [11:0]       mag_y,
   output logic              mag_iv,
   input  logic [11:0]       mag_m,
   input  logic              mag_ov,
   output logic [11:0]       out_m,
   output logic [CW-1:0]     out_ch,
   output logic              out_v,
   output logic              err
`ifdef MAG_SCHED_PEAK_EN
   ,
   output logic [12*NCH-1:0] peak,
   input  logic [NCH-1:0]    peak_clr
`endif
);
   localparam int AW = $clog2(TAGD);
   localparam int FW = $clog2(FLUSH + 2);
   typedef enum logic {S_FLUSH, S_RUN} state_t;
   state_t        state, state_nx;
   logic [FW-1:0] fcnt;
   logic [CW-1:0] ptr, g, idx;
   logic [CW-1:0] tags [TAGD];
   logic [AW-1:0] wp, rp;
   logic [AW:0]   cnt;
   logic          run, found, full, empty, xfer, pop;
   always_comb begin
      state_nx = (state == S_FLUSH && fcnt <= FW'(1)) ? S_RUN : state;
      run      = state == S_RUN;
      full     = cnt == (AW+1)'(TAGD);
      empty    = cnt == '0;
      found    = 1'b0;
      g        = '0;
      idx      = '0;
      // rotating priority search starting at the pointer
      for (int k = 0; k < NCH; k++) begin
         idx = ptr + CW'(k);
         if (!found && in_v[idx]) begin
            found = 1'b1;
            g     = idx;
         end
      end
      xfer   = run && !full && found;
      in_rdy = xfer ? {{(NCH-1){1'b0}}, 1'b1} << g : '0;
      pop    = run && mag_ov && !empty;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= (FLUSH == 0) ? S_RUN : S_FLUSH;
         fcnt   <= FW'(FLUSH);
         ptr    <= '0;
         wp     <= '0;
         rp     <= '0;
         cnt    <= '0;
         mag_x  <= '0;
         mag_y  <= '0;
         mag_iv <= 1'b0;
         out_m  <= '0;
         out_ch <= '0;
         out_v  <= 1'b0;
         err    <= 1'b0;
      end else begin
         state  <= state_nx;
         fcnt   <= (fcnt != '0) ? fcnt - 1'b1 : fcnt;
         mag_iv <= xfer;
         out_v  <= pop;
         cnt    <= cnt + {{AW{1'b0}}, xfer} - {{AW{1'b0}}, pop};
         if (xfer) begin
            mag_x <= in_x[12*g +: 12];
            mag_y <= in_y[12*g +: 12];
            ptr   <= g + 1'b1;
            wp    <= wp + 1'b1;
         end
         if (pop) begin
            out_m  <= mag_m;
            out_ch <= tags[rp];
            rp     <= rp + 1'b1;
         end
         // a result with no outstanding tag means mag12 and the scheduler are out of step
         if (run && mag_ov && empty) err <= 1'b1;
      end
   end
   always_ff @(posedge clk)
      if (xfer) tags[wp] <= g;
`ifdef MAG_SCHED_PEAK_EN
   logic [NCH-1:0][11:0] pk;
   assign peak = pk;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pk <= '0;
      else
         for (int i = 0; i < NCH; i++)
            if (peak_clr[i]) pk[i] <= '0;
            else if (out_v && out_ch == CW'(i) && out_m > pk[i]) pk[i] <= out_m;
   end
`endif
endmodule

// File: tb/tb_mag_sched.sv
// tb_mag_sched: scoreboard bench for mag_sched with a 3-cycle (or stretched) mag12 model.
module tb_mag_sched;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic [47:0] in_x = '0, in_y = '0;
   logic [3:0]  in_v = '0;
   logic [3:0]  in_rdy;
   logic [11:0] mag_x, mag_y, mag_m, out_m;
   logic        mag_iv, mag_ov, out_v, err;
   logic [1:0]  out_ch;
`ifdef MAG_SCHED_PEAK_EN
   logic [47:0] peak;
   logic [3:0]  peak_clr = '0;
`endif
   int checks = 0, errors = 0, nx = 0, nout = 0;
   int lat = 3;
   logic force_ov = 1'b0;
   logic [31:0] piv = '0;
   logic [11:0] pm [32];
   logic [11:0] exp_m [4];
   logic [13:0] q [$];
   int g_log [$], o_log [$];

   mag_sched dut (
      .clk(clk), .rst_n(rst_n), .in_x(in_x), .in_y(in_y), .in_v(in_v), .in_rdy(in_rdy),
      .mag_x(mag_x), .mag_y(mag_y), .mag_iv(mag_iv), .mag_m(mag_m), .mag_ov(mag_ov),
      .out_m(out_m), .out_ch(out_ch), .out_v(out_v), .err(err)
`ifdef MAG_SCHED_PEAK_EN
      , .peak(peak), .peak_clr(peak_clr)
`endif
   );

   always #5 clk = ~clk;
   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   function automatic logic [11:0] mag(logic signed [11:0] x, logic signed [11:0] y);
      int ax, ay;
      ax = int'(x);
      ay = int'(y);
      if (ax < 0) ax = -ax;
      if (ay < 0) ay = -ay;
      return (ax > ay) ? 12'(ax + ay / 2) : 12'(ay + ax / 2);
   endfunction

   always @(posedge clk) begin
      piv   <= {piv[30:0], mag_iv};
      pm[0] <= mag(mag_x, mag_y);
      for (int i = 1; i < 32; i++) pm[i] <= pm[i-1];
   end
   assign mag_ov = force_ov | piv[lat-1];
   assign mag_m  = pm[lat-1];

   task automatic chk(string nm, longint act, longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (out_v) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out ch=%0d m=%0d expected no output", out_ch, out_m);
         end else begin
            logic [13:0] e;
            e = q.pop_front();
            chk("out_ch", out_ch, e[13:12]);
            chk("out_m", out_m, e[11:0]);
         end
         o_log.push_back(int'(out_ch));
         nout++;
      end
   end

   task automatic tick();
      #1;
      if (in_rdy != 0) chk("rdy_onehot", $countones(in_rdy), 1);
      for (int i = 0; i < 4; i++)
         if (rst_n && in_v[i] && in_rdy[i]) begin
            q.push_back({2'(i), exp_m[i]});
            g_log.push_back(i);
            nx++;
         end
      @(negedge clk);
   endtask

   task automatic drain(string nm);
      for (int i = 0; i < 80; i++) begin
         #2;
         if (q.size() == 0) break;
         tick();
      end
      chk(nm, q.size(), 0);
   endtask

   task automatic setxy(int ch, int x, int y);
      in_x[12*ch +: 12] = 12'(x);
      in_y[12*ch +: 12] = 12'(y);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (10) tick();
   endtask

   initial begin
      int zeros, lt, n0;
      exp_m = '{12'd0, 12'd0, 12'd0, 12'd0};
      // reset and flush
      in_v = 4'b1111;
      @(negedge clk);
      #1;
      chk("rst_in_rdy", in_rdy, 0);
      chk("rst_mag_iv", mag_iv, 0);
      chk("rst_out_v", out_v, 0);
      chk("rst_err", err, 0);
      chk("rst_mag_x", mag_x, 0);
      chk("rst_out_m", out_m, 0);
      @(negedge clk);
      rst_n = 1'b1;
      zeros = 0;
      for (int i = 0; i < 20; i++) begin
         #1;
         if (in_rdy != 0) break;
         zeros++;
         @(negedge clk);
      end
      chk("flush_cycles", zeros, 8);
      g_log.delete();
      repeat (5) tick();
      in_v = 4'b0000;
      for (int i = 0; i < 5; i++) chk("s1_grant", g_log.size() > i ? g_log[i] : 99, i % 4);
      drain("s1_drain");
      // single channel latency
      setxy(2, 14, 0);
      exp_m[2] = 12'd14;
      in_v = 4'b0100;
      tick();
      in_v = 4'b0000;
      chk("s2_mag_iv", mag_iv, 1);
      chk("s2_mag_x", mag_x, 14);
      lt = 1;
      while (!out_v && lt < 20) begin
         tick();
         lt++;
      end
      chk("s2_latency", lt, 5);
      drain("s2_drain");
      // full round robin from a fresh pointer
      do_reset();
      setxy(0, 10, 10);
      setxy(1, 1000, 1000);
      setxy(2, -1414, 0);
      setxy(3, 0, -14);
      exp_m = '{12'd15, 12'd1500, 12'd1414, 12'd14};
      o_log.delete();
      in_v = 4'b1111;
      repeat (4) tick();
      in_v = 4'b0000;
      drain("s3_drain");
      chk("s3_count", o_log.size(), 4);
      for (int i = 0; i < 4; i++) chk("s3_order", o_log.size() > i ? o_log[i] : 99, i);
      // FIFO full with a slow mag12
      repeat (32) tick();
      lat = 20;
      n0 = nx;
      in_v = 4'b1111;
      for (int i = 0; i < 40; i++) begin
         #1;
         if (mag_ov) break;
         tick();
      end
      chk("s4_ov_seen", mag_ov, 1);
      chk("s4_xfers", nx - n0, 8);
      chk("s4_full_rdy", in_rdy, 0);
      tick();
      #1;
      chk("s4_reenable", in_rdy != 0, 1);
      in_v = 4'b0000;
      @(negedge clk);
      drain("s4_drain");
      repeat (4) tick();
      lat = 3;
      repeat (4) tick();
      // orphan result sets sticky error
      force_ov = 1'b1;
      tick();
      force_ov = 1'b0;
      chk("s5_err", err, 1);
      chk("s5_no_out", out_v, 0);
      repeat (3) tick();
      chk("s5_err_sticky", err, 1);
      n0 = nx;
      in_v = 4'b1111;
      repeat (3) tick();
      in_v = 4'b0000;
      chk("s5_burst", nx - n0, 3);
      rst_n = 1'b0;
      q.delete();
      #1;
      chk("s5_rst_out_m", out_m, 0);
      chk("s5_rst_out_ch", out_ch, 0);
      chk("s5_rst_err", err, 0);
      chk("s5_rst_mag_iv", mag_iv, 0);
      @(negedge clk);
      rst_n = 1'b1;
      n0 = nout;
      repeat (12) tick();
      chk("s5_stale_ignored", nout - n0, 0);
      chk("s5_err_clear", err, 0);
`ifdef MAG_SCHED_PEAK_EN
      setxy(1, 14, 0);
      exp_m[1] = 12'd14;
      in_v = 4'b0010;
      tick();
      in_v = 4'b0000;
      drain("s6_d1");
      setxy(1, 1414, 0);
      exp_m[1] = 12'd1414;
      in_v = 4'b0010;
      tick();
      in_v = 4'b0000;
      drain("s6_d2");
      setxy(1, 80, 40);
      exp_m[1] = 12'd100;
      in_v = 4'b0010;
      tick();
      in_v = 4'b0000;
      drain("s6_d3");
      tick();
      chk("s6_peak", peak[12 +: 12], 1414);
      setxy(1, 2000, 0);
      exp_m[1] = 12'd2000;
      in_v = 4'b0010;
      tick();
      in_v = 4'b0000;
      for (int i = 0; i < 20; i++) begin
         if (out_v) break;
         tick();
      end
      chk("s6_out_v", out_v, 1);
      peak_clr = 4'b0010;
      tick();
      peak_clr = 4'b0000;
      chk("s6_peak_clr", peak[12 +: 12], 0);
`endif
      drain("final_drain");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
